// File: rtl/me_frame_requester_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | me_pkg : shared defaults, FSM state type and SAD sentinel for the ME        |
// |          frame requester.                          Revision: 1.0            |
// +----------------------------------------------------------------------------+
package me_pkg;

  localparam int DEF_SAD_WIDTH      = 16;
  localparam int DEF_MVEC_WIDTH     = 12;
  localparam int DEF_MB_X_W         = 6;
  localparam int DEF_MB_Y_W         = 6;
  localparam int DEF_TIMEOUT_CYCLES = 8192;

  // Reported in place of a real SAD when the ME core never acknowledged.
  localparam logic [DEF_SAD_WIDTH-1:0] SAD_MAX = '1;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ISSUE   = 3'd1,
    ST_RELEASE = 3'd2,
    ST_ADVANCE = 3'd3,
    ST_FIN     = 3'd4
  } me_state_e;

endpackage
`default_nettype wire

// File: rtl/me_frame_requester_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | me_frame_requester_if : ME core req/ack handshake plus result stream.      |
// |                                                    Revision: 1.0            |
// +----------------------------------------------------------------------------+
interface me_frame_requester_if
  import me_pkg::*;
#(
  parameter int SAD_WIDTH  = DEF_SAD_WIDTH,
  parameter int MVEC_WIDTH = DEF_MVEC_WIDTH,
  parameter int MB_X_W     = DEF_MB_X_W,
  parameter int MB_Y_W     = DEF_MB_Y_W
) ();

  logic                  me_req;
  logic                  me_ack;
  logic [SAD_WIDTH-1:0]  me_min_sad;
  logic [MVEC_WIDTH-1:0] me_min_mvec;

  logic                  res_valid;
  logic                  res_ready;
  logic [MB_X_W-1:0]     res_mb_x;
  logic [MB_Y_W-1:0]     res_mb_y;
  logic [SAD_WIDTH-1:0]  res_sad;
  logic [MVEC_WIDTH-1:0] res_mvec;

  modport master (
    output me_req,
    input  me_ack, me_min_sad, me_min_mvec,
    output res_valid, res_mb_x, res_mb_y, res_sad, res_mvec,
    input  res_ready
  );

  modport slave (
    input  me_req,
    output me_ack, me_min_sad, me_min_mvec,
    input  res_valid, res_mb_x, res_mb_y, res_sad, res_mvec,
    output res_ready
  );

endinterface
`default_nettype wire

// File: rtl/me_mb_scan_counter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | me_mb_scan_counter : raster-order macroblock x/y counter.                   |
// |                                                    Revision: 1.0            |
// +----------------------------------------------------------------------------+
module me_mb_scan_counter
  import me_pkg::*;
#(
  parameter int MB_X_W = DEF_MB_X_W,
  parameter int MB_Y_W = DEF_MB_Y_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              step,
  input  logic [MB_X_W-1:0] width,
  input  logic [MB_Y_W-1:0] height,
  output logic [MB_X_W-1:0] mb_x,
  output logic [MB_Y_W-1:0] mb_y,
  output logic              last
);

  logic [MB_X_W-1:0] mb_x_q, mb_x_d;
  logic [MB_Y_W-1:0] mb_y_q, mb_y_d;
  logic              row_end;

  assign row_end = (mb_x_q == width - MB_X_W'(1));
  assign last    = row_end && (mb_y_q == height - MB_Y_W'(1));

  always_comb begin
    mb_x_d = mb_x_q;
    mb_y_d = mb_y_q;
    if (clear) begin
      mb_x_d = '0;
      mb_y_d = '0;
    end else if (step) begin
      if (row_end) begin
        mb_x_d = '0;
        mb_y_d = mb_y_q + MB_Y_W'(1);
      end else begin
        mb_x_d = mb_x_q + MB_X_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mb_x_q <= '0;
      mb_y_q <= '0;
    end else begin
      mb_x_q <= mb_x_d;
      mb_y_q <= mb_y_d;
    end
  end

  assign mb_x = mb_x_q;
  assign mb_y = mb_y_q;

endmodule
`default_nettype wire

// File: rtl/me_frame_requester.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | me_frame_requester : walks a frame MB by MB, issuing 4-phase ME requests    |
// |   and streaming results. ME_TIMEOUT_EN adds an ack watchdog. Revision: 1.0  |
// +----------------------------------------------------------------------------+
module me_frame_requester
  import me_pkg::*;
#(
  parameter int SAD_WIDTH      = DEF_SAD_WIDTH,
  parameter int MVEC_WIDTH     = DEF_MVEC_WIDTH,
  parameter int MB_X_W         = DEF_MB_X_W,
  parameter int MB_Y_W         = DEF_MB_Y_W
`ifdef ME_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
`endif
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [MB_X_W-1:0]   frame_mb_w,
  input  logic [MB_Y_W-1:0]   frame_mb_h,
  output logic                busy,
  output logic                done,
  output logic [MB_X_W-1:0]   mb_x,
  output logic [MB_Y_W-1:0]   mb_y,
  output logic                timeout_err,
  me_frame_requester_if.master bus
);

  me_state_e             state_q, state_d;
  logic [MB_X_W-1:0]     w_q, w_d;
  logic [MB_Y_W-1:0]     h_q, h_d;
  logic                  me_req_q, me_req_d;
  logic                  res_valid_q, res_valid_d;
  logic [MB_X_W-1:0]     res_mb_x_q, res_mb_x_d;
  logic [MB_Y_W-1:0]     res_mb_y_q, res_mb_y_d;
  logic [SAD_WIDTH-1:0]  res_sad_q, res_sad_d;
  logic [MVEC_WIDTH-1:0] res_mvec_q, res_mvec_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  scan_clear, scan_step, scan_last;
`ifdef ME_TIMEOUT_EN
  localparam int TO_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [TO_W-1:0]       to_cnt_q, to_cnt_d;
  logic                  timeout_err_q, timeout_err_d;
`endif

  me_mb_scan_counter #(
    .MB_X_W (MB_X_W),
    .MB_Y_W (MB_Y_W)
  ) u_scan (
    .clk    (clk),
    .rst    (rst),
    .clear  (scan_clear),
    .step   (scan_step),
    .width  (w_q),
    .height (h_q),
    .mb_x   (mb_x),
    .mb_y   (mb_y),
    .last   (scan_last)
  );

  always_comb begin
    state_d     = state_q;
    w_d         = w_q;
    h_d         = h_q;
    me_req_d    = me_req_q;
    res_valid_d = res_valid_q & ~bus.res_ready;
    res_mb_x_d  = res_mb_x_q;
    res_mb_y_d  = res_mb_y_q;
    res_sad_d   = res_sad_q;
    res_mvec_d  = res_mvec_q;
    done_d      = 1'b0;
    scan_clear  = 1'b0;
    scan_step   = 1'b0;
`ifdef ME_TIMEOUT_EN
    to_cnt_d      = '0;
    timeout_err_d = timeout_err_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          w_d        = frame_mb_w;
          h_d        = frame_mb_h;
          scan_clear = 1'b1;
`ifdef ME_TIMEOUT_EN
          timeout_err_d = 1'b0;
`endif
          if (frame_mb_w == '0 || frame_mb_h == '0) begin
            state_d = ST_FIN;
          end else begin
            state_d  = ST_ISSUE;
            me_req_d = 1'b1;
          end
        end
      end
      ST_ISSUE: begin
        if (bus.me_ack) begin
          me_req_d    = 1'b0;
          res_valid_d = 1'b1;
          res_mb_x_d  = mb_x;
          res_mb_y_d  = mb_y;
          res_sad_d   = bus.me_min_sad;
          res_mvec_d  = bus.me_min_mvec;
          state_d     = ST_RELEASE;
        end
`ifdef ME_TIMEOUT_EN
        else if (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
          // Unanswered request: report a worst-case SAD so the frame still completes.
          me_req_d      = 1'b0;
          timeout_err_d = 1'b1;
          res_valid_d   = 1'b1;
          res_mb_x_d    = mb_x;
          res_mb_y_d    = mb_y;
          res_sad_d     = {SAD_WIDTH{1'b1}};
          res_mvec_d    = '0;
          state_d       = ST_RELEASE;
        end else begin
          to_cnt_d = to_cnt_q + TO_W'(1);
        end
`endif
      end
      ST_RELEASE: begin
        // The single result slot must be free before the next request goes out.
        if (!bus.me_ack && (!res_valid_q || bus.res_ready)) begin
          state_d = ST_ADVANCE;
        end
      end
      ST_ADVANCE: begin
        if (scan_last) begin
          state_d = ST_FIN;
        end else begin
          scan_step = 1'b1;
          me_req_d  = 1'b1;
          state_d   = ST_ISSUE;
        end
      end
      ST_FIN: begin
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      w_q         <= '0;
      h_q         <= '0;
      me_req_q    <= 1'b0;
      res_valid_q <= 1'b0;
      res_mb_x_q  <= '0;
      res_mb_y_q  <= '0;
      res_sad_q   <= '0;
      res_mvec_q  <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
`ifdef ME_TIMEOUT_EN
      to_cnt_q      <= '0;
      timeout_err_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      w_q         <= w_d;
      h_q         <= h_d;
      me_req_q    <= me_req_d;
      res_valid_q <= res_valid_d;
      res_mb_x_q  <= res_mb_x_d;
      res_mb_y_q  <= res_mb_y_d;
      res_sad_q   <= res_sad_d;
      res_mvec_q  <= res_mvec_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
`ifdef ME_TIMEOUT_EN
      to_cnt_q      <= to_cnt_d;
      timeout_err_q <= timeout_err_d;
`endif
    end
  end

  assign busy          = busy_q;
  assign done          = done_q;
  assign bus.me_req    = me_req_q;
  assign bus.res_valid = res_valid_q;
  assign bus.res_mb_x  = res_mb_x_q;
  assign bus.res_mb_y  = res_mb_y_q;
  assign bus.res_sad   = res_sad_q;
  assign bus.res_mvec  = res_mvec_q;
`ifdef ME_TIMEOUT_EN
  assign timeout_err   = timeout_err_q;
`else
  assign timeout_err   = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_me_frame_requester.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_me_frame_requester : randomized ME responder and result sink checked    |
// |   against a raster-order expected-result queue.    Revision: 1.0            |
// +----------------------------------------------------------------------------+
module tb_me_frame_requester;
  import me_pkg::*;

  localparam int SW = 16;
  localparam int MW = 12;
  localparam int XW = 6;
  localparam int YW = 6;

  typedef struct {
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic [SW-1:0] sad;
    logic [MW-1:0] mvec;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [XW-1:0] frame_mb_w = '0;
  logic [YW-1:0] frame_mb_h = '0;
  logic          busy, done, timeout_err;
  logic [XW-1:0] mb_x;
  logic [YW-1:0] mb_y;

  int vectors = 0;
  int errors  = 0;

  me_frame_requester_if #(.SAD_WIDTH(SW), .MVEC_WIDTH(MW), .MB_X_W(XW), .MB_Y_W(YW)) bus ();

  me_frame_requester #(
    .SAD_WIDTH (SW),
    .MVEC_WIDTH(MW),
    .MB_X_W    (XW),
    .MB_Y_W    (YW)
`ifdef ME_TIMEOUT_EN
    ,
    .TIMEOUT_CYCLES(16)
`endif
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .frame_mb_w (frame_mb_w),
    .frame_mb_h (frame_mb_h),
    .busy       (busy),
    .done       (done),
    .mb_x       (mb_x),
    .mb_y       (mb_y),
    .timeout_err(timeout_err),
    .bus        (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [SW-1:0] fixed_sad(input int idx);
    case (idx % 4)
      0:       return 16'd10;
      1:       return 16'd3;
      2:       return 16'd7;
      default: return 16'd1;
    endcase
  endfunction

  task automatic test_reset();
    vectors++;
    if (busy !== 1'b0 || done !== 1'b0 || bus.me_req !== 1'b0 || bus.res_valid !== 1'b0 ||
        mb_x !== '0 || mb_y !== '0 || timeout_err !== 1'b0 || bus.res_sad !== '0) begin
      errors++;
      $display("FAIL reset_state: busy=%b done=%b req=%b rv=%b x=%0d y=%0d terr=%b sad=%h, all required 0",
               busy, done, bus.me_req, bus.res_valid, mb_x, mb_y, timeout_err, bus.res_sad);
    end
  endtask

  // One frame: bench acts as ME core and result sink, checking against raster order.
  task automatic run_frame(input int w, input int h, input int dly, input bit fixed,
                           input int ready_pct, input bit hold_first, input bit poke_start);
    exp_t q[$];
    exp_t e;
    int iss_x = 0, iss_y = 0, issued = 0, accepted = 0;
    int phase = 0, cnt = 0, cyc = 0, hold = 0;
    bit seen_first = 0, snap_v = 0, got_done = 0;
    logic [SW-1:0] snap_sad;
    logic [MW-1:0] snap_mvec;
    logic [XW-1:0] snap_x;
    logic [YW-1:0] snap_y;

    @(negedge clk);
    start = 1'b1; frame_mb_w = XW'(w); frame_mb_h = YW'(h);
    @(negedge clk);
    start = 1'b0;
    vectors++;
    if (bus.me_req !== 1'b1) begin
      errors++;
      $display("FAIL start_latency: me_req=%b required 1", bus.me_req);
    end
    while (cyc < 3000) begin
      if (done === 1'b1) begin got_done = 1; break; end
      vectors++;
      if (busy !== 1'b1) begin errors++; $display("FAIL busy_in_frame: busy=%b required 1", busy); end
      if (snap_v) begin
        vectors++;
        if (bus.res_valid !== 1'b1 || bus.res_sad !== snap_sad || bus.res_mvec !== snap_mvec ||
            bus.res_mb_x !== snap_x || bus.res_mb_y !== snap_y) begin
          errors++;
          $display("FAIL res_hold: rv=%b sad=%h mvec=%h xy=%0d,%0d required 1 %h %h %0d,%0d",
                   bus.res_valid, bus.res_sad, bus.res_mvec, bus.res_mb_x, bus.res_mb_y,
                   snap_sad, snap_mvec, snap_x, snap_y);
        end
      end
      snap_v = 0;
      // ME core responder
      case (phase)
        0: if (bus.me_req === 1'b1) begin
             vectors++;
             if (mb_x !== XW'(iss_x) || mb_y !== YW'(iss_y) || issued >= w * h) begin
               errors++;
               $display("FAIL mb_index: got %0d,%0d required %0d,%0d (issued %0d of %0d)",
                        mb_x, mb_y, iss_x, iss_y, issued, w * h);
             end
             vectors++;
             if (bus.res_valid !== 1'b0) begin
               errors++; $display("FAIL req_while_pending: res_valid=%b required 0", bus.res_valid);
             end
             cnt = fixed ? dly : int'($urandom_range(dly, 0));
             phase = 1;
           end
        1: begin
             vectors++;
             if (bus.me_req !== 1'b1 || mb_x !== XW'(iss_x) || mb_y !== YW'(iss_y)) begin
               errors++;
               $display("FAIL req_hold: req=%b xy=%0d,%0d required 1 %0d,%0d", bus.me_req, mb_x, mb_y, iss_x, iss_y);
             end
             cnt--;
             if (cnt <= 0) begin
               e.x = XW'(iss_x); e.y = YW'(iss_y);
               e.sad  = fixed ? fixed_sad(issued) : SW'($urandom);
               e.mvec = MW'($urandom);
               bus.me_min_sad = e.sad; bus.me_min_mvec = e.mvec; bus.me_ack = 1'b1;
               q.push_back(e);
               issued++;
               if (iss_x == w - 1) begin iss_x = 0; iss_y++; end else iss_x++;
               phase = 2;
             end
           end
        2: begin
             vectors++;
             if (bus.me_req !== 1'b0 || bus.res_valid !== 1'b1) begin
               errors++;
               $display("FAIL ack_response: req=%b rv=%b required 0 1", bus.me_req, bus.res_valid);
             end
             cnt = int'($urandom_range(2, 0));
             phase = 3;
           end
        default: begin
             vectors++;
             if (bus.me_req !== 1'b0) begin errors++; $display("FAIL req_during_ack: req=%b required 0", bus.me_req); end
             if (cnt == 0) begin
               bus.me_ack = 1'b0; bus.me_min_sad = SW'($urandom); bus.me_min_mvec = MW'($urandom);
               phase = 0;
             end else cnt--;
           end
      endcase
      // Result sink
      if (bus.res_valid === 1'b1) begin
        if (!seen_first) begin seen_first = 1; if (hold_first) hold = 10; end
        if (hold > 0) begin
          hold--;
          bus.res_ready = 1'b0;
          vectors++;
          if (bus.me_req !== 1'b0) begin errors++; $display("FAIL backpressure_req: req=%b required 0", bus.me_req); end
        end else bus.res_ready = ($urandom_range(99, 0) < ready_pct);
        if (bus.res_ready) begin
          vectors++;
          if (q.size() == 0) begin
            errors++; $display("FAIL result_unexpected: sad=%h with nothing outstanding", bus.res_sad);
          end else begin
            e = q.pop_front();
            accepted++;
            if (bus.res_mb_x !== e.x || bus.res_mb_y !== e.y || bus.res_sad !== e.sad || bus.res_mvec !== e.mvec) begin
              errors++;
              $display("FAIL result: got %0d,%0d sad=%h mvec=%h required %0d,%0d sad=%h mvec=%h",
                       bus.res_mb_x, bus.res_mb_y, bus.res_sad, bus.res_mvec, e.x, e.y, e.sad, e.mvec);
            end
          end
        end else begin
          snap_v = 1; snap_sad = bus.res_sad; snap_mvec = bus.res_mvec;
          snap_x = bus.res_mb_x; snap_y = bus.res_mb_y;
        end
      end else bus.res_ready = 1'($urandom_range(1, 0));
      if (poke_start && cyc == 6) begin start = 1'b1; frame_mb_w = 1; frame_mb_h = 1; end
      if (poke_start && cyc == 7) start = 1'b0;
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    vectors++;
    if (!got_done || accepted != w * h || q.size() != 0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL frame_end: done_seen=%0d accepted=%0d busy=%b required 1 %0d 0", got_done, accepted, busy, w * h);
    end
    bus.me_ack = 1'b0;
    @(negedge clk);
    vectors++;
    if (done !== 1'b0) begin errors++; $display("FAIL done_pulse: done=%b required 0", done); end
  endtask

  task automatic test_basic_2x2();
    run_frame(2, 2, 5, 1'b1, 100, 1'b0, 1'b0);
  endtask

  task automatic test_backpressure();
    run_frame(2, 2, 2, 1'b0, 100, 1'b1, 1'b0);
  endtask

  task automatic test_zero_dim(input int w, input int h);
    @(negedge clk);
    start = 1'b1; frame_mb_w = XW'(w); frame_mb_h = YW'(h);
    @(negedge clk);
    start = 1'b0;
    vectors++;
    if (done !== 1'b0 || busy !== 1'b1 || bus.me_req !== 1'b0) begin
      errors++; $display("FAIL zero_fin: done=%b busy=%b req=%b required 0 1 0", done, busy, bus.me_req);
    end
    @(negedge clk);
    vectors++;
    if (done !== 1'b1 || busy !== 1'b0 || bus.me_req !== 1'b0) begin
      errors++; $display("FAIL zero_done: done=%b busy=%b req=%b required 1 0 0", done, busy, bus.me_req);
    end
    @(negedge clk);
    vectors++;
    if (done !== 1'b0) begin errors++; $display("FAIL zero_done_pulse: done=%b required 0", done); end
  endtask

  task automatic test_reset_mid();
    int n = 0;
    @(negedge clk);
    start = 1'b1; frame_mb_w = 3; frame_mb_h = 3;
    @(negedge clk);
    start = 1'b0;
    while (bus.me_req !== 1'b1 && n < 10) begin @(negedge clk); n++; end
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    vectors++;
    if (bus.me_req !== 1'b0 || busy !== 1'b0 || bus.res_valid !== 1'b0) begin
      errors++; $display("FAIL async_reset: req=%b busy=%b rv=%b required 0 0 0", bus.me_req, busy, bus.res_valid);
    end
    @(negedge clk);
    rst = 1'b0;
    run_frame(2, 3, 3, 1'b0, 70, 1'b0, 1'b0);
  endtask

  task automatic test_start_while_busy();
    run_frame(3, 2, 2, 1'b0, 80, 1'b0, 1'b1);
  endtask

  task automatic test_random();
    for (int i = 0; i < 5; i++) begin
      run_frame(int'($urandom_range(4, 1)), int'($urandom_range(3, 1)), int'($urandom_range(4, 0)),
                1'b0, 50, 1'b0, 1'b0);
    end
  endtask

`ifdef ME_TIMEOUT_EN
  task automatic test_timeout();
    int n = 0;
    @(negedge clk);
    start = 1'b1; frame_mb_w = 1; frame_mb_h = 1; bus.res_ready = 1'b0; bus.me_ack = 1'b0;
    @(negedge clk);
    start = 1'b0;
    while (bus.me_req === 1'b1 && n < 100) begin @(negedge clk); n++; end
    vectors++;
    if (n != 16 || timeout_err !== 1'b1 || bus.res_valid !== 1'b1 || bus.res_sad !== SAD_MAX || bus.res_mvec !== '0) begin
      errors++;
      $display("FAIL timeout: req_cycles=%0d terr=%b rv=%b sad=%h mvec=%h required 16 1 1 ffff 0",
               n, timeout_err, bus.res_valid, bus.res_sad, bus.res_mvec);
    end
    bus.res_ready = 1'b1;
    n = 0;
    while (done !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    vectors++;
    if (done !== 1'b1 || timeout_err !== 1'b1) begin
      errors++; $display("FAIL timeout_done: done=%b terr=%b required 1 1", done, timeout_err);
    end
    run_frame(1, 1, 1, 1'b0, 100, 1'b0, 1'b0);
    vectors++;
    if (timeout_err !== 1'b0) begin errors++; $display("FAIL timeout_clear: terr=%b required 0", timeout_err); end
  endtask
`endif

  initial begin
    bus.me_ack = 1'b0; bus.me_min_sad = '0; bus.me_min_mvec = '0; bus.res_ready = 1'b0;
    repeat (3) @(negedge clk);
    test_reset();
    rst = 1'b0;
    @(negedge clk);
    test_reset();
    test_basic_2x2();
    test_backpressure();
    test_zero_dim(0, 3);
    test_zero_dim(4, 0);
    test_reset_mid();
    test_start_while_busy();
    test_random();
`ifdef ME_TIMEOUT_EN
    test_timeout();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
`default_nettype wire
